branch_resolve_unit: RTL and testbench

- Parametrised, registered successor to the combinational branch condition handler. Sits in the ID stage.
- Decodes the full MIPS control-flow set: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL, JR, JALR.
- Uses signed full-width compares, computes targets, and tracks the branch delay slot with an FSM.
- Issues a one-cycle fetch redirect, the link-register write request, and saturating branch statistics.

---
 rtl/branch_resolve_if.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// ID-stage control-flow bus: decoded instruction fields in, fetch redirect,
// link-register write and branch statistics out.
interface branch_resolve_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              stall;
    logic [5:0]        opcode;
    logic [4:0]        rt_field;
    logic [4:0]        rd_field;
    logic [5:0]        funct;
    logic [25:0]       imm26;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] pc;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              link_we;
    logic [4:0]        link_reg;
    logic [DATA_W-1:0] link_data;
    logic              ds_branch_err;
    logic              busy;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output in_valid, stall, opcode, rt_field, rd_field, funct, imm26,
               rs_val, rt_val, pc,
        input  redirect_valid, redirect_pc, link_we, link_reg, link_data,
               ds_branch_err, busy, br_count, taken_count
    );

    modport slave (
        input  in_valid, stall, opcode, rt_field, rd_field, funct, imm26,
               rs_val, rt_val, pc,
        output redirect_valid, redirect_pc, link_we, link_reg, link_data,
               ds_branch_err, busy, br_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered MIPS control-flow resolver: decode, signed condition, target,
// delay-slot tracking, link write request and saturating statistics.
module branch_resolve_unit #(
    parameter int DATA_W     = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             reset,
    branch_resolve_if.slave bus
);
    typedef enum logic {IDLE, WAIT_DS} state_t;

    state_t            state;
    logic [DATA_W-1:0] pend_tgt;

    logic              accept;
    logic              is_cf;
    logic              taken;
    logic              links;
    logic              is_jalr;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] br_tgt;
    logic [DATA_W-1:0] j_tgt;
    logic [DATA_W-1:0] link_addr;
    logic signed [DATA_W-1:0] rs_s;
    logic signed [DATA_W-1:0] rt_s;

    assign accept    = bus.in_valid & ~bus.stall;
    assign rs_s      = bus.rs_val;
    assign rt_s      = bus.rt_val;
    assign pc4       = bus.pc + DATA_W'(4);
    assign br_tgt    = pc4 + {{(DATA_W-18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
    assign j_tgt     = {pc4[DATA_W-1:28], bus.imm26, 2'b00};
    assign link_addr = (DELAY_SLOT != 0) ? bus.pc + DATA_W'(8) : pc4;
    assign is_jalr   = (bus.opcode == 6'h00) && (bus.funct == 6'h09);

    always_comb begin
        is_cf  = 1'b0;
        taken  = 1'b0;
        links  = 1'b0;
        target = br_tgt;
        case (bus.opcode)
            6'h00: begin
                if (bus.funct == 6'h08 || bus.funct == 6'h09) begin
                    is_cf  = 1'b1;
                    taken  = 1'b1;
                    links  = is_jalr;
                    target = bus.rs_val;
                end
            end
            6'h01: begin
                // REGIMM: bit 0 of rt_field picks >=0 vs <0, bit 4 adds the link
                case (bus.rt_field)
                    5'b00000, 5'b10000: begin
                        is_cf = 1'b1;
                        taken = rs_s < 0;
                        links = bus.rt_field[4];
                    end
                    5'b00001, 5'b10001: begin
                        is_cf = 1'b1;
                        taken = rs_s >= 0;
                        links = bus.rt_field[4];
                    end
                    default: ;
                endcase
            end
            6'h02, 6'h03: begin
                is_cf  = 1'b1;
                taken  = 1'b1;
                links  = bus.opcode[0];
                target = j_tgt;
            end
            6'h04: begin is_cf = 1'b1; taken = rs_s == rt_s; end
            6'h05: begin is_cf = 1'b1; taken = rs_s != rt_s; end
            6'h06: begin is_cf = 1'b1; taken = rs_s <= 0;    end
            6'h07: begin is_cf = 1'b1; taken = rs_s > 0;     end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            pend_tgt           <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.link_we        <= 1'b0;
            bus.link_reg       <= '0;
            bus.link_data      <= '0;
            bus.ds_branch_err  <= 1'b0;
            bus.busy           <= 1'b0;
            bus.br_count       <= '0;
            bus.taken_count    <= '0;
        end else begin
            bus.redirect_valid <= 1'b0;
            bus.link_we        <= 1'b0;
            bus.ds_branch_err  <= 1'b0;
            if (accept) begin
                if (state == WAIT_DS) begin
                    // Delay-slot instruction: release the redirect; a nested
                    // branch here is flagged and otherwise ignored.
                    bus.redirect_valid <= 1'b1;
                    bus.redirect_pc    <= pend_tgt;
                    bus.ds_branch_err  <= is_cf;
                    bus.busy           <= 1'b0;
                    state              <= IDLE;
                end else if (is_cf) begin
                    if (bus.br_count != '1)
                        bus.br_count <= bus.br_count + CNT_W'(1);
                    if (links) begin
                        bus.link_we   <= 1'b1;
                        bus.link_reg  <= is_jalr ? bus.rd_field : 5'd31;
                        bus.link_data <= link_addr;
                    end
                    if (taken) begin
                        if (bus.taken_count != '1)
                            bus.taken_count <= bus.taken_count + CNT_W'(1);
                        if (DELAY_SLOT != 0) begin
                            pend_tgt <= target;
                            bus.busy <= 1'b1;
                            state    <= WAIT_DS;
                        end else begin
                            bus.redirect_valid <= 1'b1;
                            bus.redirect_pc    <= target;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Two DUT flavours (delay slot / no delay slot with 2-bit counters) share one
// stimulus stream; an architectural model predicts both, checked every cycle.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall;
    logic [5:0]  opcode, funct;
    logic [4:0]  rt_field, rd_field;
    logic [25:0] imm26;
    logic [31:0] rs_val, rt_val, pc;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_if #(.DATA_W(32), .CNT_W(16)) ifa ();
    branch_resolve_if #(.DATA_W(32), .CNT_W(2))  ifb ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.stall    = stall;     assign ifb.stall    = stall;
    assign ifa.opcode   = opcode;    assign ifb.opcode   = opcode;
    assign ifa.rt_field = rt_field;  assign ifb.rt_field = rt_field;
    assign ifa.rd_field = rd_field;  assign ifb.rd_field = rd_field;
    assign ifa.funct    = funct;     assign ifb.funct    = funct;
    assign ifa.imm26    = imm26;     assign ifb.imm26    = imm26;
    assign ifa.rs_val   = rs_val;    assign ifb.rs_val   = rs_val;
    assign ifa.rt_val   = rt_val;    assign ifb.rt_val   = rt_val;
    assign ifa.pc       = pc;        assign ifb.pc       = pc;

    branch_resolve_unit #(.DATA_W(32), .DELAY_SLOT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    branch_resolve_unit #(.DATA_W(32), .DELAY_SLOT(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    logic [31:0] a_rv[2], a_rpc[2], a_lwe[2], a_lreg[2], a_ldata[2];
    logic [31:0] a_err[2], a_busy[2], a_br[2], a_tk[2];
    always_comb begin
        a_rv[0] = 32'(ifa.redirect_valid); a_rv[1] = 32'(ifb.redirect_valid);
        a_rpc[0] = ifa.redirect_pc;        a_rpc[1] = ifb.redirect_pc;
        a_lwe[0] = 32'(ifa.link_we);       a_lwe[1] = 32'(ifb.link_we);
        a_lreg[0] = 32'(ifa.link_reg);     a_lreg[1] = 32'(ifb.link_reg);
        a_ldata[0] = ifa.link_data;        a_ldata[1] = ifb.link_data;
        a_err[0] = 32'(ifa.ds_branch_err); a_err[1] = 32'(ifb.ds_branch_err);
        a_busy[0] = 32'(ifa.busy);         a_busy[1] = 32'(ifb.busy);
        a_br[0] = 32'(ifa.br_count);       a_br[1] = 32'(ifb.br_count);
        a_tk[0] = 32'(ifa.taken_count);    a_tk[1] = 32'(ifb.taken_count);
    end

    // model state and expected outputs, index 0 = dut_a, 1 = dut_b
    bit          m_ds[2]   = '{1'b1, 1'b0};
    int          m_max[2]  = '{65535, 3};
    bit          m_pend[2];
    logic [31:0] m_ptgt[2];
    logic [31:0] e_rv[2], e_rpc[2], e_lwe[2], e_lreg[2], e_ldata[2];
    logic [31:0] e_err[2], e_busy[2], e_br[2], e_tk[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic decode(output bit cf, output bit tk, output logic [31:0] tgt, output bit lk);
        int signed rs, rt;
        logic [31:0] bt, jt;
        rs = rs_val; rt = rt_val;
        bt = pc + 32'd4 + 32'(signed'(imm26[15:0])) * 4;
        jt = ((pc + 32'd4) & 32'hF000_0000) | (32'(imm26) * 4);
        cf = 0; tk = 0; tgt = bt; lk = 0;
        if (opcode == 0 && (funct == 8 || funct == 9)) begin
            cf = 1; tk = 1; tgt = rs_val; lk = (funct == 9);
        end else if (opcode == 1 && (rt_field == 0 || rt_field == 16)) begin
            cf = 1; tk = rs < 0; lk = (rt_field == 16);
        end else if (opcode == 1 && (rt_field == 1 || rt_field == 17)) begin
            cf = 1; tk = rs >= 0; lk = (rt_field == 17);
        end else if (opcode == 2 || opcode == 3) begin
            cf = 1; tk = 1; tgt = jt; lk = (opcode == 3);
        end else if (opcode == 4) begin cf = 1; tk = rs == rt;
        end else if (opcode == 5) begin cf = 1; tk = rs != rt;
        end else if (opcode == 6) begin cf = 1; tk = rs <= 0;
        end else if (opcode == 7) begin cf = 1; tk = rs > 0;
        end
    endtask

    task automatic model_tick();
        bit cf, tk, lk;
        logic [31:0] tgt;
        decode(cf, tk, tgt, lk);
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 0; e_lwe[k] = 0; e_err[k] = 0;
            if (reset) begin
                m_pend[k] = 0; e_rpc[k] = 0; e_br[k] = 0; e_tk[k] = 0;
                e_lreg[k] = 0; e_ldata[k] = 0;
            end else if (in_valid && !stall) begin
                if (m_pend[k]) begin
                    e_rv[k] = 1; e_rpc[k] = m_ptgt[k]; m_pend[k] = 0;
                    e_err[k] = 32'(cf);
                end else if (cf) begin
                    if (e_br[k] < 32'(m_max[k])) e_br[k]++;
                    if (lk) begin
                        e_lwe[k] = 1;
                        e_lreg[k] = (opcode == 0) ? 32'(rd_field) : 31;
                        e_ldata[k] = m_ds[k] ? pc + 8 : pc + 4;
                    end
                    if (tk) begin
                        if (e_tk[k] < 32'(m_max[k])) e_tk[k]++;
                        if (m_ds[k]) begin m_pend[k] = 1; m_ptgt[k] = tgt; end
                        else begin e_rv[k] = 1; e_rpc[k] = tgt; end
                    end
                end
            end
            e_busy[k] = 32'(m_pend[k]);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("redirect_valid[%0d]", k), a_rv[k], e_rv[k]);
                check($sformatf("redirect_pc[%0d]", k), a_rpc[k], e_rpc[k]);
                check($sformatf("link_we[%0d]", k), a_lwe[k], e_lwe[k]);
                if (e_lwe[k] == 1) begin
                    check($sformatf("link_reg[%0d]", k), a_lreg[k], e_lreg[k]);
                    check($sformatf("link_data[%0d]", k), a_ldata[k], e_ldata[k]);
                end
                check($sformatf("ds_branch_err[%0d]", k), a_err[k], e_err[k]);
                check($sformatf("busy[%0d]", k), a_busy[k], e_busy[k]);
                check($sformatf("br_count[%0d]", k), a_br[k], e_br[k]);
                check($sformatf("taken_count[%0d]", k), a_tk[k], e_tk[k]);
            end
        end
    end

    task automatic ins(input logic [5:0] op, input logic [4:0] rtf, input logic [4:0] rdf,
                       input logic [5:0] fn, input logic [25:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] p);
        opcode = op; rt_field = rtf; rd_field = rdf; funct = fn; imm26 = imm;
        rs_val = rs; rt_val = rt; pc = p;
    endtask

    task automatic step(input bit v, input bit s);
        in_valid = v; stall = s;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic nop();
        ins(6'h00, 5'd0, 5'd0, 6'h00, 26'd0, 32'd0, 32'd0, 32'h900);
        step(1, 0);
    endtask

    task automatic do_reset();
        reset = 1; step(0, 0); reset = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; stall = 0;
        ins(6'h00, 5'd0, 5'd0, 6'h00, 26'd0, 32'd0, 32'd0, 32'd0);
        step(0, 0);
        started = 1'b1;
        check("reset_rv", a_rv[0], 0);
        check("reset_br", a_br[0], 0);
        check("reset_busy", a_busy[0], 0);
        reset = 0;

        // BEQ back to itself, redirect after delay slot
        ins(6'h04, 5'd0, 5'd0, 6'h00, 26'h0FFFF, 32'd5, 32'd5, 32'h100);
        step(1, 0);
        check("beq_no_early_rv", a_rv[0], 0);
        check("beq_busy", a_busy[0], 1);
        nop();
        check("beq_ds_rv", a_rv[0], 1);
        check("beq_ds_rpc", a_rpc[0], 32'h100);
        check("beq_br", a_br[0], 1);
        check("beq_tk", a_tk[0], 1);
        step(0, 1);
        check("pulse_one_cycle", a_rv[0], 0);
        check("rpc_hold", a_rpc[0], 32'h100);

        // BGEZAL not taken still links
        do_reset();
        ins(6'h01, 5'b10001, 5'd0, 6'h00, 26'h00010, 32'hFFFF_FFFF, 32'd0, 32'h200);
        step(1, 0);
        check("bgezal_lwe", a_lwe[0], 1);
        check("bgezal_lreg", a_lreg[0], 31);
        check("bgezal_ldata", a_ldata[0], 32'h208);
        check("bgezal_ldata_nods", a_ldata[1], 32'h204);
        check("bgezal_tk", a_tk[0], 0);
        check("bgezal_busy", a_busy[0], 0);

        // JALR with stalled delay slot
        do_reset();
        ins(6'h00, 5'd0, 5'd7, 6'h09, 26'd0, 32'h4000, 32'd0, 32'h300);
        step(1, 0);
        check("jalr_lreg", a_lreg[0], 7);
        check("jalr_ldata", a_ldata[0], 32'h308);
        ins(6'h00, 5'd0, 5'd0, 6'h00, 26'd0, 32'd0, 32'd0, 32'h304);
        for (int i = 0; i < 3; i++) begin
            step(1, 1);
            check("jalr_stall_busy", a_busy[0], 1);
            check("jalr_stall_rv", a_rv[0], 0);
        end
        step(0, 0);
        check("jalr_idle_busy", a_busy[0], 1);
        step(1, 0);
        check("jalr_rv", a_rv[0], 1);
        check("jalr_rpc", a_rpc[0], 32'h4000);

        // taken BNE with J in the delay slot
        do_reset();
        ins(6'h05, 5'd0, 5'd0, 6'h00, 26'h00010, 32'd1, 32'd2, 32'h400);
        step(1, 0);
        check("bne_nods_rpc", a_rpc[1], 32'h444);
        ins(6'h02, 5'd0, 5'd0, 6'h00, 26'h0000123, 32'd0, 32'd0, 32'h404);
        step(1, 0);
        check("ds_err", a_err[0], 1);
        check("ds_err_rpc", a_rpc[0], 32'h444);
        check("ds_err_br", a_br[0], 1);
        check("ds_err_nods_rpc", a_rpc[1], 32'h48C);

        // J without delay slot keeps PC top bits
        do_reset();
        ins(6'h02, 5'd0, 5'd0, 6'h00, 26'h10, 32'd0, 32'd0, 32'h1000_0004);
        step(1, 0);
        check("j_nods_rv", a_rv[1], 1);
        check("j_nods_rpc", a_rpc[1], 32'h1000_0040);
        check("j_nods_lwe", a_lwe[1], 0);

        // reset while waiting on the delay slot discards the target
        do_reset();
        ins(6'h04, 5'd0, 5'd0, 6'h00, 26'h00020, 32'd3, 32'd3, 32'h600);
        step(1, 0);
        check("pre_reset_busy", a_busy[0], 1);
        do_reset();
        nop();
        check("post_reset_rv", a_rv[0], 0);
        check("post_reset_br", a_br[0], 0);
        check("post_reset_tk", a_tk[0], 0);
        nop();

        // misc conditions, sign extension, invalid REGIMM, JR/JAL
        do_reset();
        ins(6'h06, 5'd0, 5'd0, 6'h00, 26'h00002, 32'd0, 32'd0, 32'h500);
        step(1, 0);
        check("blez_zero_rpc", a_rpc[1], 32'h50C);
        nop();
        ins(6'h07, 5'd0, 5'd0, 6'h00, 26'h00002, 32'd0, 32'd0, 32'h510); step(1, 0); nop();
        ins(6'h07, 5'd0, 5'd0, 6'h00, 26'h08000, 32'd9, 32'd0, 32'h40000); step(1, 0); nop();
        ins(6'h01, 5'b00000, 5'd0, 6'h00, 26'h00004, 32'hFFFF_FFFB, 32'd0, 32'h520); step(1, 0); nop();
        ins(6'h01, 5'b00001, 5'd0, 6'h00, 26'h00004, 32'd0, 32'd0, 32'h530); step(1, 0); nop();
        ins(6'h01, 5'b10000, 5'd0, 6'h00, 26'h00004, 32'd4, 32'd0, 32'h540); step(1, 0); nop();
        ins(6'h01, 5'b00010, 5'd0, 6'h00, 26'h00004, 32'hFFFF_FFFF, 32'd0, 32'h550); step(1, 0);
        check("regimm_invalid_br", a_br[0], 6);
        ins(6'h00, 5'd0, 5'd0, 6'h08, 26'd0, 32'h8000_0000, 32'd0, 32'h560); step(1, 0); nop();
        ins(6'h03, 5'd0, 5'd0, 6'h00, 26'h3FF_FFFF, 32'd0, 32'd0, 32'hF000_0000); step(1, 0);
        check("jal_lreg", a_lreg[0], 31);
        nop();
        check("jal_rpc", a_rpc[0], 32'hFFFF_FFFC);

        // saturation: 5 taken branches
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ins(6'h04, 5'd0, 5'd0, 6'h00, 26'h00001, 32'd1, 32'd1, 32'h700 + 32'(i * 16));
            step(1, 0);
            nop();
        end
        check("sat_tk_a", a_tk[0], 5);
        check("sat_tk_b", a_tk[1], 3);
        check("sat_br_b", a_br[1], 3);
        step(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
